i2c_reg_master: RTL

I2C_REG_MASTER -- requirements
Module: i2c_reg_master

---
 rtl/i2c_reg_master.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/i2c_reg_master.sv
// I2C register master: single-byte register write or read over open-drain SCL/SDA.
// Define I2C_CLOCK_STRETCH_EN to honour slave clock stretching on scl_i.
module i2c_reg_master #(
    parameter int CLK_DIV = 125
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       in_val_i,
    input  logic [6:0] in_daddr_i,
    input  logic [7:0] in_addr_i,
    input  logic [7:0] in_data_i,
    input  logic       in_wen_i,
    output logic       in_rdy_o,
    output logic       out_val_o,
    output logic       out_err_o,
    output logic [7:0] out_data_o,
    input  logic       out_rdy_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_o,
    output logic       scl_t,
    output logic       sda_o,
    output logic       sda_t
);
    localparam int CW = $clog2(CLK_DIV);

    typedef enum logic [2:0] {
        IDLE, START, BYTE, ACK, RSTART, STOP, BUSFREE, RESP
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt;
    logic [1:0]      qtr;
    logic [2:0]      bit_cnt;
    logic [1:0]      byte_idx;
    logic [7:0]      shreg;
    logic [7:0]      rdata;
    logic [6:0]      daddr;
    logic [7:0]      addr;
    logic [7:0]      data;
    logic            wen;
    logic            err;
    logic            rdy_en;
    logic            hold;
    logic            tick;
    logic            bit_end;
    logic            sample;
    logic            accept;
    logic [7:0]      next_byte;

`ifdef I2C_CLOCK_STRETCH_EN
    // A released SCL still read low means the slave is stretching.
    assign hold = scl_t & ~scl_i;
`else
    logic scl_unused;
    assign scl_unused = scl_i;
    assign hold = 1'b0;
`endif

    assign tick      = (cnt == CW'(CLK_DIV - 1)) && !hold;
    assign bit_end   = tick && (qtr == 2'd3);
    assign sample    = tick && (qtr == 2'd1);
    assign in_rdy_o  = (state == IDLE) && rdy_en;
    assign accept    = in_val_i && in_rdy_o;
    assign out_val_o = (state == RESP);
    assign out_err_o = err;
    assign out_data_o = rdata;
    assign scl_o     = 1'b0;
    assign sda_o     = 1'b0;

    assign next_byte = (byte_idx == 2'd0) ? addr :
                       (wen ? data : {daddr, 1'b1});

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = START;
            START:   if (bit_end) state_next = BYTE;
            RSTART:  if (bit_end) state_next = BYTE;
            BYTE:    if (bit_end && bit_cnt == 3'd7) state_next = ACK;
            ACK: begin
                if (bit_end) begin
                    if (err || byte_idx == 2'd3) begin
                        state_next = STOP;
                    end else if (wen && byte_idx == 2'd2) begin
                        state_next = STOP;
                    end else if (!wen && byte_idx == 2'd1) begin
                        state_next = RSTART;
                    end else begin
                        state_next = BYTE;
                    end
                end
            end
            STOP:    if (bit_end) state_next = BUSFREE;
            BUSFREE: if (bit_end) state_next = RESP;
            RESP:    if (out_rdy_i) state_next = IDLE;
        endcase
    end

    // Bit cell: q0 SCL low (SDA may change), q1-q2 SCL high, q3 SCL low.
    always_comb begin
        scl_t = 1'b1;
        sda_t = 1'b1;
        unique case (state)
            START: begin
                sda_t = !qtr[1];
                scl_t = (qtr != 2'd3);
            end
            BYTE, ACK: begin
                scl_t = (qtr == 2'd1) || (qtr == 2'd2);
                sda_t = (state == ACK) || (byte_idx == 2'd3) || shreg[7];
            end
            RSTART: begin
                scl_t = (qtr == 2'd1) || (qtr == 2'd2);
                sda_t = !qtr[1];
            end
            STOP: begin
                scl_t = (qtr != 2'd0);
                sda_t = qtr[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt      <= '0;
            qtr      <= 2'd0;
            bit_cnt  <= 3'd0;
            byte_idx <= 2'd0;
            shreg    <= 8'h00;
            rdata    <= 8'h00;
            daddr    <= 7'h00;
            addr     <= 8'h00;
            data     <= 8'h00;
            wen      <= 1'b0;
            err      <= 1'b0;
            rdy_en   <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (state == IDLE || state == RESP) begin
                cnt <= '0;
                qtr <= 2'd0;
            end else if (tick) begin
                cnt <= '0;
                qtr <= qtr + 2'd1;
            end else if (!hold) begin
                cnt <= cnt + 1'b1;
            end
            if (accept) begin
                daddr    <= in_daddr_i;
                addr     <= in_addr_i;
                data     <= in_data_i;
                wen      <= in_wen_i;
                shreg    <= {in_daddr_i, 1'b0};
                bit_cnt  <= 3'd0;
                byte_idx <= 2'd0;
                err      <= 1'b0;
                rdata    <= 8'h00;
            end
            if (state == BYTE && sample && byte_idx == 2'd3) begin
                rdata <= {rdata[6:0], sda_i};
            end
            if (state == BYTE && bit_end) begin
                bit_cnt <= bit_cnt + 3'd1;
                shreg   <= {shreg[6:0], 1'b0};
            end
            if (state == ACK && sample && byte_idx != 2'd3 && sda_i) begin
                err <= 1'b1;
            end
            if (state == ACK && bit_end) begin
                byte_idx <= byte_idx + 2'd1;
                shreg    <= next_byte;
            end
        end
    end

endmodule
